// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Conditions two bouncy, asynchronous push-buttons into clean one-cycle
//   command pulses for the calculator state machine. Each button gets its own
//   synchronizer and debounce FSM; a small arbiter keeps the two pulses from
//   ever coinciding.
//
// Ports
//   clk        in   system clock, rising-edge active
//   reset      in   asynchronous active-low reset
//   btn_p_raw  in   raw "advance" button (async, active-high, bouncy)
//   btn_d_raw  in   raw "back" button (async, active-high, bouncy)
//   BP         out  one-cycle pulse per accepted advance press (registered)
//   BD         out  one-cycle pulse per accepted back press (registered)
//   btn_level  out  debounced levels, [1] = advance, [0] = back
// ---------------------------------------------------------------------------

// One debounce channel: two-flop synchronizer followed by a four-state FSM.
// press_o is a combinational request, asserted on the edge that accepts the
// press; the parent registers it.
module button_conditioner_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic press_o,
    output logic level_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sync_q;
    logic             in_s;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the two
    // synchronizer stages into one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b00;
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Only the second synchronizer stage is ever looked at.
    assign in_s = sync_q[1];

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = CNT_ZERO;
                if (in_s) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!in_s) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = CNT_ZERO;
                    press_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                cnt_d = CNT_ZERO;
                if (!in_s) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (in_s) begin
                    // Glitch low during a hold: back to PRESSED, no new pulse.
                    state_d = PRESSED;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    assign level_o = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_p_raw,
    input  logic       btn_d_raw,
    output logic       BP,
    output logic       BD,
    output logic [1:0] btn_level
);

    logic req_p, req_d;
    logic lvl_p, lvl_d;
    logic bp_q, bp_d;
    logic bd_q, bd_d;
    logic bd_pending_q, bd_pending_d;
    logic bd_want;

    button_conditioner_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_p (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (btn_p_raw),
        .press_o (req_p),
        .level_o (lvl_p)
    );

    button_conditioner_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_d (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (btn_d_raw),
        .press_o (req_d),
        .level_o (lvl_d)
    );

    // Advance always wins a collision. A back request that loses is parked in
    // a one-deep flag; a further back request while parked merges into it.
    // The channel FSMs never wait on this arbitration.
    always_comb begin
        bd_want      = bd_pending_q | req_d;
        bp_d         = req_p;
        bd_d         = bd_want & ~req_p;
        bd_pending_d = bd_want & req_p;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bp_q         <= 1'b0;
            bd_q         <= 1'b0;
            bd_pending_q <= 1'b0;
        end else begin
            bp_q         <= bp_d;
            bd_q         <= bd_d;
            bd_pending_q <= bd_pending_d;
        end
    end

    assign BP        = bp_q;
    assign BD        = bd_q;
    assign btn_level = {lvl_p, lvl_d};

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//   Directed bench for button_conditioner with DEBOUNCE_CYCLES = 4.
//   Inputs change 1 ns after a falling edge; outputs are checked at the same
//   point, so each step() shows the state left by the preceding rising edge.
//   With a raw input changed at step k, the pulse (and level change) for a
//   held press appears at step k+7 (2 synchronizer edges + entry edge + 4
//   counted samples).
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_p_raw = 1'b0;
    logic       btn_d_raw = 1'b0;
    logic       BP;
    logic       BD;
    logic [1:0] btn_level;

    int n_assert = 0;
    int n_fail   = 0;
    int bp_count = 0;
    int bd_count = 0;
    int overlap  = 0;

    button_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_p_raw (btn_p_raw),
        .btn_d_raw (btn_d_raw),
        .BP        (BP),
        .BD        (BD),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    // Pulse monitor: one sample per cycle, away from the rising edge.
    always @(negedge clk) begin
        if (BP === 1'b1) bp_count++;
        if (BD === 1'b1) bd_count++;
        if (BP === 1'b1 && BD === 1'b1) overlap++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_bp", {31'b0, BP}, 0);
        chk("rst_bd", {31'b0, BD}, 0);
        chk("rst_level", {30'b0, btn_level}, 0);
        step();
        step();
        reset = 1'b1;
        repeat (3) step();

        // Clean advance press, held 20 cycles
        btn_p_raw = 1'b1;
        repeat (6) step();
        chk("clean_bp_early", {31'b0, BP}, 0);
        chk("clean_level_early", {30'b0, btn_level}, 0);
        step();
        chk("clean_bp_pulse", {31'b0, BP}, 1);
        chk("clean_bd_quiet", {31'b0, BD}, 0);
        chk("clean_level_set", {30'b0, btn_level}, 2);
        step();
        chk("clean_bp_one_cycle", {31'b0, BP}, 0);
        chk("clean_level_hold", {30'b0, btn_level}, 2);
        repeat (12) step();
        chk("clean_bp_count", bp_count, 1);
        btn_p_raw = 1'b0;
        repeat (6) step();
        chk("clean_rel_level_hold", {30'b0, btn_level}, 2);
        step();
        chk("clean_rel_level_fall", {30'b0, btn_level}, 0);
        repeat (3) step();
        chk("clean_no_release_pulse", bp_count, 1);
        chk("clean_bd_count", bd_count, 0);

        // Back-button bounce: 1,0,1,1,0,0 then settle
        btn_d_raw = 1'b1; step(); chk("bounce_lvl_0", {30'b0, btn_level}, 0);
        btn_d_raw = 1'b0; step(); chk("bounce_lvl_1", {30'b0, btn_level}, 0);
        btn_d_raw = 1'b1; step(); chk("bounce_lvl_2", {30'b0, btn_level}, 0);
        btn_d_raw = 1'b1; step(); chk("bounce_lvl_3", {30'b0, btn_level}, 0);
        btn_d_raw = 1'b0; step(); chk("bounce_lvl_4", {30'b0, btn_level}, 0);
        btn_d_raw = 1'b0; step(); chk("bounce_lvl_5", {30'b0, btn_level}, 0);
        repeat (4) step();
        chk("bounce_lvl_settled", {30'b0, btn_level}, 0);
        chk("bounce_no_bd", bd_count, 0);
        // Then a real hold of 10 cycles
        btn_d_raw = 1'b1;
        repeat (6) step();
        chk("back_bd_early", {31'b0, BD}, 0);
        step();
        chk("back_bd_pulse", {31'b0, BD}, 1);
        chk("back_level_set", {30'b0, btn_level}, 1);
        repeat (3) step();
        chk("back_bd_count", bd_count, 1);
        btn_d_raw = 1'b0;
        repeat (10) step();
        chk("back_level_clear", {30'b0, btn_level}, 0);

        // Release glitch on advance
        btn_p_raw = 1'b1;
        repeat (10) step();
        chk("glitch_pressed", {30'b0, btn_level}, 2);
        chk("glitch_bp_count_a", bp_count, 2);
        btn_p_raw = 1'b0;
        step();
        step();
        chk("glitch_level_low2", {30'b0, btn_level}, 2);
        btn_p_raw = 1'b1;
        step();
        chk("glitch_level_high1", {30'b0, btn_level}, 2);
        btn_p_raw = 1'b0;
        repeat (6) step();
        chk("glitch_level_still", {30'b0, btn_level}, 2);
        step();
        chk("glitch_level_fall", {30'b0, btn_level}, 0);
        repeat (5) step();
        chk("glitch_no_second_bp", bp_count, 2);

        // Simultaneous presses
        btn_p_raw = 1'b1;
        btn_d_raw = 1'b1;
        repeat (6) step();
        chk("simul_bp_early", {31'b0, BP}, 0);
        step();
        chk("simul_bp_n", {31'b0, BP}, 1);
        chk("simul_bd_n", {31'b0, BD}, 0);
        step();
        chk("simul_bp_n1", {31'b0, BP}, 0);
        chk("simul_bd_n1", {31'b0, BD}, 1);
        step();
        chk("simul_bd_n2", {31'b0, BD}, 0);
        btn_p_raw = 1'b0;
        btn_d_raw = 1'b0;
        repeat (10) step();
        chk("simul_bp_count", bp_count, 3);
        chk("simul_bd_count", bd_count, 2);

        // Reset mid-debounce while the back button is held
        btn_d_raw = 1'b1;
        repeat (8) step();
        chk("mid_back_held", {30'b0, btn_level}, 1);
        chk("mid_bd_count", bd_count, 3);
        btn_p_raw = 1'b1;
        repeat (4) step();
        #2;
        reset = 1'b0;
        btn_d_raw = 1'b0;
        #1;
        chk("mid_rst_bp", {31'b0, BP}, 0);
        chk("mid_rst_bd", {31'b0, BD}, 0);
        chk("mid_rst_level", {30'b0, btn_level}, 0);
        step();
        step();
        reset = 1'b1;
        repeat (6) step();
        chk("mid_after_bp_early", {31'b0, BP}, 0);
        step();
        chk("mid_after_bp_pulse", {31'b0, BP}, 1);
        chk("mid_after_level", {30'b0, btn_level}, 2);
        repeat (10) step();
        chk("mid_after_bp_count", bp_count, 4);
        chk("mid_after_bd_count", bd_count, 3);
        btn_p_raw = 1'b0;
        repeat (10) step();

        // Reset while a back pulse is pending
        btn_p_raw = 1'b1;
        btn_d_raw = 1'b1;
        repeat (7) step();
        chk("pend_bp_pulse", {31'b0, BP}, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("pend_rst_bp", {31'b0, BP}, 0);
        btn_p_raw = 1'b0;
        btn_d_raw = 1'b0;
        step();
        step();
        reset = 1'b1;
        repeat (10) step();
        chk("pend_bd_discarded", bd_count, 3);
        chk("pend_bp_count", bp_count, 5);
        chk("pend_level", {30'b0, btn_level}, 0);

        chk("never_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), number of consecutive stable synchronized samples required to accept a level change; legal range >= 2.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of clk.
REQ-004 btn_p_raw  input  1  raw "advance" push-button, asynchronous to clk, active-high, may bounce.
REQ-005 btn_d_raw  input  1  raw "back" push-button, asynchronous to clk, active-high, may bounce.
REQ-006 BP  output  1  one-cycle pulse per accepted press of btn_p_raw; feeds the calculator state machine.
REQ-007 BD  output  1  one-cycle pulse per accepted press of btn_d_raw; feeds the calculator state machine.
REQ-008 btn_level  output  2  debounced levels, bit 1 = advance, bit 0 = back.

Function
REQ-009 Each raw input SHALL pass through its own two-flop synchronizer reset to 0; no downstream logic uses an unsynchronized input.
REQ-010 Each channel SHALL run an identical FSM: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, with a counter of width $clog2(DEBOUNCE_CYCLES).
REQ-011 IDLE: synchronized input 1 -> PRESS_WAIT, counter = 0; else stay.
REQ-012 PRESS_WAIT: input 0 -> IDLE, counter cleared; input 1 and counter = DEBOUNCE_CYCLES-1 -> PRESSED and request a press pulse; otherwise increment counter.
REQ-013 PRESSED: input 0 -> RELEASE_WAIT, counter = 0; else stay.
REQ-014 RELEASE_WAIT: input 1 -> PRESSED, counter cleared, no pulse; input 0 and counter = DEBOUNCE_CYCLES-1 -> IDLE; otherwise increment counter.
REQ-015 btn_level bit SHALL be 1 exactly when its channel is in PRESSED or RELEASE_WAIT.
REQ-016 Latency: raw input first sampled high at edge t0 and held -> pulse registered at edge t0+DEBOUNCE_CYCLES+2, high for exactly one cycle.
REQ-017 No pulse on release; holding a button indefinitely SHALL give exactly one pulse (no auto-repeat).
REQ-018 Bounce shorter than DEBOUNCE_CYCLES consecutive samples SHALL produce no pulse and no btn_level change.
REQ-019 BP and BD SHALL never be high in the same cycle.
REQ-020 Simultaneous requests on one edge: BP issued that cycle; BD held in a one-deep pending flag and issued the next cycle.
REQ-021 A new BD request arriving while a BD is pending SHALL merge with it (one BD pulse); channel FSMs are never stalled by arbitration.
REQ-022 BP and BD SHALL be registered outputs (no combinational path from raw inputs).

Reset
REQ-023 reset = 0 SHALL asynchronously force: synchronizers 0, both FSMs IDLE, counters 0, pending flag 0, BP = 0, BD = 0, btn_level = 2'b00.
REQ-024 Reset asserted mid-debounce or with a BD pending SHALL discard the in-flight press; no pulse is emitted for it after release.
REQ-025 Reset release is synchronous-safe: the first state update occurs on the first rising clk edge after reset = 1; a button held through reset SHALL then be debounced from scratch and yield exactly one pulse.

Verification (DEBOUNCE_CYCLES = 4)
REQ-026 Clean press: btn_p_raw 0->1 sampled first at edge 10, held 20 cycles -> BP high only in the cycle after edge 16, btn_level[1] = 1 from edge 16, BD never high.
REQ-027 Bounce: btn_d_raw toggles 1,0,1,1,0 on consecutive edges then 0 -> no BD pulse, btn_level[0] stays 0; then held high 10 cycles -> exactly one BD pulse.
REQ-028 Release glitch: advance held, released for 2 cycles, high again for 1 cycle, released for 10 -> no second BP, btn_level[1] falls only after 4 consecutive low samples.
REQ-029 Simultaneous: both raw inputs rise on the same edge and hold -> BP in cycle N, BD in cycle N+1, never together.
REQ-030 Reset mid-operation: reset = 0 asynchronously (between edges) during PRESS_WAIT with btn_p_raw held -> BP, BD, btn_level go 0 immediately; after reset = 1, one BP appears DEBOUNCE_CYCLES+2 edges later.
